rs_entry_allocator: RTL and testbench

- Dispatch-side bookkeeping for one reservation station: tracks busy entries and allocates up to two free entries per cycle.
- Maintains a per-entry age rank and drives the packed ent/val vectors consumed by the issue-side oldest-entry selector.
- An entry leaves the station when the selector issues it, which frees its slot.
- Smaller val means older; idle entries always sort last.

---
 rtl/rs_entry_allocator.sv | 141 ++++++++++++++
 tb/tb_rs_entry_allocator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_entry_allocator.sv
`default_nettype none
// ============================================================================
// Module   : rs_entry_allocator
// Function : Reservation-station entry bookkeeping. Grants up to two free
//            entries per cycle, frees the entry being issued, and keeps a
//            dense age rank per busy entry for the oldest-first selector.
// Options  : define RS_FLUSH_EN to add a synchronous 'flush' input.
// Revision : 1.0  initial release
// ============================================================================
module rs_entry_allocator #(
  parameter int ENTNUM  = 8,
  parameter int ENTLEN  = 3,
  parameter int RANKLEN = ENTLEN,
  parameter int VALLEN  = RANKLEN + 1
) (
  input  logic                       clk,
  input  logic                       reset_x,
`ifdef RS_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic [1:0]                 req_num,
  output logic                       alloc_ok,
  output logic [ENTLEN-1:0]          alloc_ent1,
  output logic [ENTLEN-1:0]          alloc_ent2,
  input  logic                       issue_valid,
  input  logic [ENTLEN-1:0]          issue_ent,
  output logic [ENTNUM-1:0]          busyvec,
  output logic [ENTNUM*VALLEN-1:0]   valvec,
  output logic [ENTNUM*ENTLEN-1:0]   entvec,
  output logic [ENTLEN:0]            free_cnt,
  output logic                       full
);

  logic [ENTNUM-1:0]  busy;
  logic [RANKLEN-1:0] rank     [ENTNUM];
  logic [ENTNUM-1:0]  busy_nxt;
  logic [RANKLEN-1:0] rank_nxt [ENTNUM];

  logic [ENTLEN:0]    busycount;
  logic [1:0]         req_eff;
  logic               flush_now;
  logic               issue_hit;
  logic               do_alloc;
  logic [RANKLEN-1:0] issue_rank;
  logic [RANKLEN-1:0] new_rank;
  logic               found1;
  logic               found2;

`ifdef RS_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  // Encoding 3 is illegal on req_num and behaves as no request.
  assign req_eff = (req_num == 2'd3) ? 2'd0 : req_num;

  // Count busy entries; free count and full flag derive from registered state only.
  always_comb begin
    busycount = '0;
    for (int i = 0; i < ENTNUM; i++) begin
      busycount = busycount + (ENTLEN+1)'(busy[i]);
    end
  end

  assign free_cnt = (ENTLEN+1)'(ENTNUM) - busycount;
  assign full     = (free_cnt == '0);
  assign alloc_ok = !flush_now && (free_cnt >= (ENTLEN+1)'(req_eff));
  assign do_alloc = alloc_ok && (req_eff != 2'd0);

  // Pick the lowest and next-lowest free entries; zero when none exists.
  always_comb begin
    alloc_ent1 = '0;
    alloc_ent2 = '0;
    found1     = 1'b0;
    found2     = 1'b0;
    for (int i = 0; i < ENTNUM; i++) begin
      if (!busy[i]) begin
        if (!found1) begin
          alloc_ent1 = ENTLEN'(i);
          found1     = 1'b1;
        end else if (!found2) begin
          alloc_ent2 = ENTLEN'(i);
          found2     = 1'b1;
        end
      end
    end
  end

  assign issue_hit  = issue_valid && busy[issue_ent];
  assign issue_rank = rank[issue_ent];
  // New entries queue behind every entry that survives this cycle's issue.
  assign new_rank   = RANKLEN'(busycount - (ENTLEN+1)'(issue_hit));

  // Next busy/rank state: issue frees and compacts ranks, allocation appends.
  always_comb begin
    for (int i = 0; i < ENTNUM; i++) begin
      busy_nxt[i] = busy[i];
      rank_nxt[i] = rank[i];
      if (issue_hit && (ENTLEN'(i) == issue_ent)) begin
        busy_nxt[i] = 1'b0;
        rank_nxt[i] = '0;
      end else if (issue_hit && busy[i] && (rank[i] > issue_rank)) begin
        rank_nxt[i] = rank[i] - 1'b1;
      end
      if (do_alloc && (ENTLEN'(i) == alloc_ent1)) begin
        busy_nxt[i] = 1'b1;
        rank_nxt[i] = new_rank;
      end
      if (do_alloc && (req_eff == 2'd2) && (ENTLEN'(i) == alloc_ent2)) begin
        busy_nxt[i] = 1'b1;
        rank_nxt[i] = new_rank + 1'b1;
      end
    end
  end

  // State register; flush (when present) wins over issue and allocation.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      busy <= '0;
      for (int i = 0; i < ENTNUM; i++) rank[i] <= '0;
    end else if (flush_now) begin
      busy <= '0;
      for (int i = 0; i < ENTNUM; i++) rank[i] <= '0;
    end else begin
      busy <= busy_nxt;
      for (int i = 0; i < ENTNUM; i++) rank[i] <= rank_nxt[i];
    end
  end

  assign busyvec = busy;

  generate
    for (genvar g = 0; g < ENTNUM; g++) begin : g_ent
      assign valvec[g*VALLEN +: VALLEN] = {~busy[g], rank[g]};
      assign entvec[g*ENTLEN +: ENTLEN] = ENTLEN'(g);
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rs_entry_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_entry_allocator
// Function : Bench for rs_entry_allocator. The reference keeps busy entries
//            as an age-ordered list (oldest first); rank = list position.
// Options  : honours RS_FLUSH_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_rs_entry_allocator;

  localparam int ENTNUM = 8;
  localparam int ENTLEN = 3;
  localparam int VALLEN = 4;

  logic                      clk = 1'b0;
  logic                      reset_x = 1'b0;
  logic [1:0]                req_num = '0;
  logic                      issue_valid = 1'b0;
  logic [ENTLEN-1:0]         issue_ent = '0;
`ifdef RS_FLUSH_EN
  logic                      flush = 1'b0;
`endif
  logic                      alloc_ok;
  logic [ENTLEN-1:0]         alloc_ent1;
  logic [ENTLEN-1:0]         alloc_ent2;
  logic [ENTNUM-1:0]         busyvec;
  logic [ENTNUM*VALLEN-1:0]  valvec;
  logic [ENTNUM*ENTLEN-1:0]  entvec;
  logic [ENTLEN:0]           free_cnt;
  logic                      full;

  int n_checks = 0;
  int n_fail   = 0;
  int age_q[$];

  rs_entry_allocator dut (
    .clk         (clk),
    .reset_x     (reset_x),
`ifdef RS_FLUSH_EN
    .flush       (flush),
`endif
    .req_num     (req_num),
    .alloc_ok    (alloc_ok),
    .alloc_ent1  (alloc_ent1),
    .alloc_ent2  (alloc_ent2),
    .issue_valid (issue_valid),
    .issue_ent   (issue_ent),
    .busyvec     (busyvec),
    .valvec      (valvec),
    .entvec      (entvec),
    .free_cnt    (free_cnt),
    .full        (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pos_q(input int e);
    for (int k = 0; k < age_q.size(); k++) if (age_q[k] == e) return k;
    return -1;
  endfunction

  // k-th (0-based) free entry by ascending index, 0 if there is none
  function automatic int nth_free(input int k);
    int seen = 0;
    for (int i = 0; i < ENTNUM; i++) begin
      if (pos_q(i) < 0) begin
        if (seen == k) return i;
        seen++;
      end
    end
    return 0;
  endfunction

  function automatic bit grant(input int req, input bit fl);
    int r = (req == 3) ? 0 : req;
    return !fl && ((ENTNUM - age_q.size()) >= r);
  endfunction

  task automatic check_all(input string ph, input int req, input bit fl);
    logic [ENTNUM-1:0]        bv;
    logic [ENTNUM*VALLEN-1:0] vv;
    logic [ENTNUM*ENTLEN-1:0] ev;
    int free;
    free = ENTNUM - age_q.size();
    for (int i = 0; i < ENTNUM; i++) begin
      bv[i] = (pos_q(i) >= 0);
      vv[i*VALLEN +: VALLEN] = bv[i] ? {1'b0, 3'(pos_q(i))} : 4'b1000;
      ev[i*ENTLEN +: ENTLEN] = 3'(i);
    end
    chk({ph, " busyvec"},  64'(busyvec),    64'(bv));
    chk({ph, " valvec"},   64'(valvec),     64'(vv));
    chk({ph, " entvec"},   64'(entvec),     64'(ev));
    chk({ph, " free_cnt"}, 64'(free_cnt),   64'(free));
    chk({ph, " full"},     64'(full),       64'(free == 0));
    chk({ph, " alloc_ok"}, 64'(alloc_ok),   64'(grant(req, fl)));
    chk({ph, " ent1"},     64'(alloc_ent1), 64'(nth_free(0)));
    chk({ph, " ent2"},     64'(alloc_ent2), 64'(nth_free(1)));
  endtask

  // One clock: drive, check before the edge, advance the reference, take the edge.
  task automatic cycle(input int req, input bit iv, input int ie, input bit fl, input string ph);
    int r;
    int e1;
    int e2;
    bit ok;
    int p;
    req_num     = 2'(req);
    issue_valid = iv;
    issue_ent   = 3'(ie);
`ifdef RS_FLUSH_EN
    flush       = fl;
`endif
    @(negedge clk);
    check_all(ph, req, fl);
    r  = (req == 3) ? 0 : req;
    e1 = nth_free(0);
    e2 = nth_free(1);
    ok = grant(req, fl);
    if (fl) begin
      age_q.delete();
    end else begin
      p = pos_q(ie);
      if (iv && p >= 0) age_q.delete(p);
      if (ok && r >= 1) age_q.push_back(e1);
      if (ok && r == 2) age_q.push_back(e2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_num     = '0;
    issue_valid = 1'b0;
    issue_ent   = '0;
    reset_x     = 1'b0;
    #1;
    age_q.delete();
    check_all("reset", 0, 1'b0);
    @(negedge clk);
    reset_x = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int iv;
    int ie;
    do_reset();
    chk("reset valvec const", 64'(valvec), 64'h8888_8888);
    chk("reset free const", 64'(free_cnt), 64'd8);
    cycle(0, 0, 0, 0, "idle");

    // Fill all eight entries two at a time, then over-request.
    for (int k = 0; k < 4; k++) cycle(2, 0, 0, 0, "fill");
    cycle(1, 0, 0, 0, "overflow");
    chk("full flag", 64'(full), 64'd1);

    // Issue the middle entry and watch the younger ones compact.
    cycle(0, 1, 3, 0, "issue3");
    cycle(0, 0, 0, 0, "after_issue3");
    chk("entry3 idle val", 64'(valvec[12 +: 4]), 64'h8);
    chk("entry7 rank", 64'(valvec[28 +: 4]), 64'h6);

    cycle(2, 0, 0, 0, "deny2");
    cycle(0, 1, 3, 0, "issue_idle");
    cycle(3, 0, 0, 0, "req3");
    cycle(0, 0, 0, 0, "after_req3");

    // Five busy, then simultaneous issue of the oldest and a double allocation.
    do_reset();
    cycle(2, 0, 0, 0, "five_a");
    cycle(2, 0, 0, 0, "five_b");
    cycle(1, 0, 0, 0, "five_c");
    cycle(2, 1, 0, 0, "issue_alloc");
    cycle(0, 0, 0, 0, "after_issue_alloc");
    chk("entry5 rank", 64'(valvec[20 +: 4]), 64'h4);
    chk("entry6 rank", 64'(valvec[24 +: 4]), 64'h5);

    // Asynchronous reset in the middle of a cycle with six entries busy.
    do_reset();
    for (int k = 0; k < 3; k++) cycle(2, 0, 0, 0, "six");
    req_num = '0;
    #2;
    reset_x = 1'b0;
    #1;
    age_q.delete();
    check_all("async_rst", 0, 1'b0);
    @(negedge clk);
    reset_x = 1'b1;
    @(posedge clk);
    #1;

`ifdef RS_FLUSH_EN
    cycle(2, 0, 0, 0, "pre_flush");
    cycle(2, 0, 0, 0, "pre_flush2");
    cycle(2, 1, 0, 1, "flush");
    cycle(0, 0, 0, 0, "after_flush");
`endif

    // Randomised traffic, issues biased toward busy entries.
    for (int n = 0; n < 400; n++) begin
      iv = ($urandom_range(0, 99) < 60) ? 1 : 0;
      if (age_q.size() > 0 && $urandom_range(0, 3) != 0)
        ie = age_q[$urandom_range(0, age_q.size() - 1)];
      else
        ie = $urandom_range(0, ENTNUM - 1);
`ifdef RS_FLUSH_EN
      cycle($urandom_range(0, 3), iv[0], ie, ($urandom_range(0, 49) == 0), "rand");
`else
      cycle($urandom_range(0, 3), iv[0], ie, 1'b0, "rand");
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
